// File: rtl/dff8_negedge_rst.sv
// Falling-edge register bank with a synchronous, active-high reset that
// loads a fixed non-zero pattern. It gives a half-cycle offset from the
// posedge domain: d captured at a falling edge is visible to posedge logic
// half a cycle later.
module dff8_negedge_rst #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = 8'h34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Falling-edge capture. Reset is sampled only on this edge, so it is
  // synchronous, and it takes priority over d.
  always_ff @(negedge clk) begin
    if (reset) q <= RESET_VALUE;
    else       q <= d;
  end

endmodule

// File: tb/tb_dff8_negedge_rst.sv
// Bench for dff8_negedge_rst. Inputs are driven between edges. Expected q
// values go into a scoreboard queue and are compared just after each
// falling edge. q is also checked just after each rising edge, where it
// must hold its previous value.
module tb_dff8_negedge_rst;
  localparam logic [7:0] RV = 8'h34;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] d = 8'h00;
  logic [7:0] q;

  dff8_negedge_rst #(.WIDTH(8), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset(reset), .d(d), .q(q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl[7];
  logic [7:0] exp_q[$];
  logic [7:0] model;
  logic       model_ok = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: q=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, q=%h expected=none", name, q);
    end else begin
      e = exp_q.pop_front();
      check(name, q, e);
      model = e;
      model_ok = 1'b1;
    end
  endtask

  // One full cycle. Just after the rising edge, check that q still holds
  // its value. Then drive new inputs and queue the expected result. Just
  // after the falling edge, check that result.
  task automatic step(input logic r, input logic [7:0] dv, input logic [7:0] exp,
                      input string name);
    @(posedge clk); #1;
    if (model_ok) check({name, "_hold"}, q, model);
    reset = r;
    d = dv;
    exp_q.push_back(exp);
    @(negedge clk); #1;
    pop_check(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: q=%h expected=finish before timeout", q);
    $fatal(1, "timeout");
  end

  initial begin
    logic       r;
    logic [7:0] dv;

    tbl[0] = '{1'b1, 8'hA5, 8'h34};  // reset held across two falling edges
    tbl[1] = '{1'b1, 8'hA5, 8'h34};
    tbl[2] = '{1'b0, 8'h81, 8'h81};  // first edge out of reset loads d
    tbl[3] = '{1'b0, 8'h3C, 8'h3C};
    tbl[4] = '{1'b1, 8'h00, 8'h34};  // reset beats d
    tbl[5] = '{1'b0, 8'hFF, 8'hFF};
    tbl[6] = '{1'b0, 8'h09, 8'h09};

    for (int i = 0; i < 7; i++)
      step(tbl[i].rst, tbl[i].d, tbl[i].exp, $sformatf("vec%0d", i));

    // Reset raised right after a falling edge: no effect until the next one.
    reset = 1'b1;
    @(posedge clk); #1;
    check("sync_rst_hold", q, 8'h09);
    @(negedge clk); #1;
    check("sync_rst_take", q, RV);

    // d changes exactly at a rising edge: q keeps its old value until the
    // falling edge.
    reset = 1'b0;
    d = 8'h12;
    @(negedge clk); #1;
    check("d_load12", q, 8'h12);
    @(posedge clk);
    d = 8'hFF;
    #1;
    check("d_posedge_hold", q, 8'h12);
    @(negedge clk); #1;
    check("d_loadFF", q, 8'hFF);
    model = 8'hFF;

    // Random: 200 cycles give 400 half-cycle checks against the
    // falling-edge model.
    for (int i = 0; i < 200; i++) begin
      r  = ($urandom_range(15) == 0);
      dv = 8'($urandom);
      step(r, dv, r ? RV : dv, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
